// File: rtl/ysyx_22050133_lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_22050133_lsu_pkg
//  Brief    : Access-size encodings, LSU state encoding and crossing helper.
//  Revision : 1.0
// ============================================================================
package ysyx_22050133_lsu_pkg;

    localparam logic [1:0] c_SIZE_B = 2'd0;
    localparam logic [1:0] c_SIZE_H = 2'd1;
    localparam logic [1:0] c_SIZE_W = 2'd2;
    localparam logic [1:0] c_SIZE_D = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ0  = 3'd1,
        ST_WAIT0 = 3'd2,
        ST_REQ1  = 3'd3,
        ST_WAIT1 = 3'd4,
        ST_RESP  = 3'd5
    } lsu_state_t;

    // True when the last byte of the access falls past the current bus word.
    function automatic logic access_crosses(input int unsigned off,
                                            input logic [1:0]  size,
                                            input int unsigned bytes);
        return (off + (32'd1 << size) - 32'd1) >= bytes;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_22050133_lsu_align.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_22050133_lsu_align
//  Brief    : Byte-lane placement, strobe generation and load extension.
//  Revision : 1.0
// ============================================================================
module ysyx_22050133_lsu_align
    import ysyx_22050133_lsu_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int BUS_W = 64,
    parameter int BYTES = BUS_W / 8,
    parameter int OFF_W = $clog2(BYTES)
) (
    input  logic [1:0]       i_size,
    input  logic             i_unsigned,
    input  logic [OFF_W-1:0] i_off,
    input  logic [XLEN-1:0]  i_wdata,
    input  logic [BUS_W-1:0] i_beat0,
    input  logic [BUS_W-1:0] i_beat1,
    output logic [BUS_W-1:0] o_wdata_lo,
    output logic [BUS_W-1:0] o_wdata_hi,
    output logic [BYTES-1:0] o_wstrb_lo,
    output logic [BYTES-1:0] o_wstrb_hi,
    output logic [XLEN-1:0]  o_rdata
);

    logic [2*BUS_W-1:0] w_wwide;
    logic [2*BYTES-1:0] w_sbase;
    logic [2*BYTES-1:0] w_swide;
    logic [XLEN-1:0]    w_raw;

    always_comb begin
        w_wwide = {{(2*BUS_W-XLEN){1'b0}}, i_wdata} << {i_off, 3'b000};
        w_sbase = ~({(2*BYTES){1'b1}} << (32'd1 << i_size));
        w_swide = w_sbase << i_off;
        w_raw   = XLEN'({i_beat1, i_beat0} >> {i_off, 3'b000});

        o_wdata_lo = w_wwide[BUS_W-1:0];
        o_wdata_hi = w_wwide[2*BUS_W-1:BUS_W];
        o_wstrb_lo = w_swide[BYTES-1:0];
        o_wstrb_hi = w_swide[2*BYTES-1:BYTES];

        case (i_size)
            c_SIZE_B: o_rdata = {{(XLEN-8){~i_unsigned & w_raw[7]}},   w_raw[7:0]};
            c_SIZE_H: o_rdata = {{(XLEN-16){~i_unsigned & w_raw[15]}}, w_raw[15:0]};
            c_SIZE_W: o_rdata = {{(XLEN-32){~i_unsigned & w_raw[31]}}, w_raw[31:0]};
            default:  o_rdata = w_raw;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ysyx_22050133_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_22050133_lsu
//  Brief    : MEM-stage load/store unit with valid/ready handshakes on both sides.
//  Revision : 1.0
// ============================================================================
module ysyx_22050133_lsu
    import ysyx_22050133_lsu_pkg::*;
#(
    parameter int XLEN             = 64,
    parameter int ADDR_W           = 64,
    parameter int BUS_W            = 64,
    parameter int SPLIT_MISALIGNED = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [XLEN-1:0]     rsp_rdata,
    output logic                rsp_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_req_write,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic [BUS_W-1:0]    mem_req_wdata,
    output logic [BUS_W/8-1:0]  mem_req_wstrb,
    input  logic                mem_rsp_valid,
    input  logic [BUS_W-1:0]    mem_rsp_rdata,
    input  logic                mem_rsp_err,
    output logic                busy
);

    localparam int BYTES = BUS_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam logic [ADDR_W-1:0] c_lane_mask = ADDR_W'(BYTES - 1);
    localparam logic [ADDR_W-1:0] c_beat_step = ADDR_W'(BYTES);

    lsu_state_t        r_state_q, w_state_d;
    logic              r_write_q, w_write_d;
    logic [1:0]        r_size_q, w_size_d;
    logic              r_unsigned_q, w_unsigned_d;
    logic [ADDR_W-1:0] r_addr_q, w_addr_d;
    logic [XLEN-1:0]   r_wdata_q, w_wdata_d;
    logic              r_cross_q, w_cross_d;
    logic              r_err_q, w_err_d;
    logic [BUS_W-1:0]  r_beat0_q, w_beat0_d;
    logic [BUS_W-1:0]  r_beat1_q, w_beat1_d;
    logic              r_req_ready_q, r_mem_req_valid_q, r_rsp_valid_q, r_busy_q;

    logic [BUS_W-1:0]  w_wdata_lo, w_wdata_hi;
    logic [BYTES-1:0]  w_wstrb_lo, w_wstrb_hi;
    logic [XLEN-1:0]   w_load_data;
    logic              w_beat1_sel;
    logic [ADDR_W-1:0] w_base;

    ysyx_22050133_lsu_align #(
        .XLEN  (XLEN),
        .BUS_W (BUS_W)
    ) u_align (
        .i_size     (r_size_q),
        .i_unsigned (r_unsigned_q),
        .i_off      (r_addr_q[OFF_W-1:0]),
        .i_wdata    (r_wdata_q),
        .i_beat0    (r_beat0_q),
        .i_beat1    (r_beat1_q),
        .o_wdata_lo (w_wdata_lo),
        .o_wdata_hi (w_wdata_hi),
        .o_wstrb_lo (w_wstrb_lo),
        .o_wstrb_hi (w_wstrb_hi),
        .o_rdata    (w_load_data)
    );

    always_comb begin
        w_state_d    = r_state_q;
        w_write_d    = r_write_q;
        w_size_d     = r_size_q;
        w_unsigned_d = r_unsigned_q;
        w_addr_d     = r_addr_q;
        w_wdata_d    = r_wdata_q;
        w_cross_d    = r_cross_q;
        w_err_d      = r_err_q;
        w_beat0_d    = r_beat0_q;
        w_beat1_d    = r_beat1_q;
        case (r_state_q)
            ST_IDLE: begin
                if (req_valid && r_req_ready_q) begin
                    w_write_d    = req_write;
                    w_size_d     = req_size;
                    w_unsigned_d = req_unsigned;
                    w_addr_d     = req_addr;
                    w_wdata_d    = req_wdata;
                    w_beat0_d    = '0;
                    w_beat1_d    = '0;
                    w_cross_d    = access_crosses(int'(req_addr[OFF_W-1:0]), req_size, BYTES);
                    // A crossing access with splitting disabled never touches the bus.
                    if (w_cross_d && (SPLIT_MISALIGNED == 0)) begin
                        w_err_d   = 1'b1;
                        w_state_d = ST_RESP;
                    end else begin
                        w_err_d   = 1'b0;
                        w_state_d = ST_REQ0;
                    end
                end
            end
            ST_REQ0:  if (mem_req_ready) w_state_d = ST_WAIT0;
            ST_WAIT0: begin
                if (mem_rsp_valid) begin
                    w_beat0_d = mem_rsp_rdata;
                    w_err_d   = r_err_q | mem_rsp_err;
                    w_state_d = r_cross_q ? ST_REQ1 : ST_RESP;
                end
            end
            ST_REQ1:  if (mem_req_ready) w_state_d = ST_WAIT1;
            ST_WAIT1: begin
                if (mem_rsp_valid) begin
                    w_beat1_d = mem_rsp_rdata;
                    w_err_d   = r_err_q | mem_rsp_err;
                    w_state_d = ST_RESP;
                end
            end
            ST_RESP:  if (rsp_ready) w_state_d = ST_IDLE;
            default:  w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q         <= ST_IDLE;
            r_write_q         <= 1'b0;
            r_size_q          <= 2'd0;
            r_unsigned_q      <= 1'b0;
            r_addr_q          <= '0;
            r_wdata_q         <= '0;
            r_cross_q         <= 1'b0;
            r_err_q           <= 1'b0;
            r_beat0_q         <= '0;
            r_beat1_q         <= '0;
            r_req_ready_q     <= 1'b0;
            r_mem_req_valid_q <= 1'b0;
            r_rsp_valid_q     <= 1'b0;
            r_busy_q          <= 1'b0;
        end else begin
            r_state_q         <= w_state_d;
            r_write_q         <= w_write_d;
            r_size_q          <= w_size_d;
            r_unsigned_q      <= w_unsigned_d;
            r_addr_q          <= w_addr_d;
            r_wdata_q         <= w_wdata_d;
            r_cross_q         <= w_cross_d;
            r_err_q           <= w_err_d;
            r_beat0_q         <= w_beat0_d;
            r_beat1_q         <= w_beat1_d;
            r_req_ready_q     <= (w_state_d == ST_IDLE);
            r_mem_req_valid_q <= (w_state_d == ST_REQ0) || (w_state_d == ST_REQ1);
            r_rsp_valid_q     <= (w_state_d == ST_RESP);
            r_busy_q          <= (w_state_d != ST_IDLE);
        end
    end

    // Bus-side fields are forced to zero whenever no beat is being offered.
    assign w_beat1_sel   = (r_state_q == ST_REQ1);
    assign w_base        = r_addr_q & ~c_lane_mask;
    assign mem_req_valid = r_mem_req_valid_q;
    assign mem_req_write = r_mem_req_valid_q & r_write_q;
    assign mem_req_addr  = !r_mem_req_valid_q ? '0 :
                           (w_beat1_sel ? (w_base + c_beat_step) : w_base);
    assign mem_req_wdata = !(r_mem_req_valid_q && r_write_q) ? '0 :
                           (w_beat1_sel ? w_wdata_hi : w_wdata_lo);
    assign mem_req_wstrb = !(r_mem_req_valid_q && r_write_q) ? '0 :
                           (w_beat1_sel ? w_wstrb_hi : w_wstrb_lo);

    assign rsp_valid = r_rsp_valid_q;
    assign rsp_err   = r_rsp_valid_q & r_err_q;
    assign rsp_rdata = (r_rsp_valid_q && !r_write_q) ? w_load_data : '0;
    assign req_ready = r_req_ready_q;
    assign busy      = r_busy_q;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22050133_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ysyx_22050133_lsu
//  Brief    : Directed self-checking bench for the LSU (split and no-split builds).
//  Revision : 1.0
// ============================================================================
module tb_ysyx_22050133_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_valid2 = 1'b0;
    logic        req_write = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [63:0] req_addr = '0, req_wdata = '0;
    logic        rsp_ready = 1'b0, rsp_ready2 = 1'b0;
    logic        mem_req_ready = 1'b0, mem_rsp_valid = 1'b0, mem_rsp_err = 1'b0;
    logic [63:0] mem_rsp_rdata = '0;

    logic        req_ready, rsp_valid, rsp_err, mem_req_valid, mem_req_write, busy;
    logic [63:0] rsp_rdata, mem_req_addr, mem_req_wdata;
    logic [7:0]  mem_req_wstrb;

    logic        req_ready2, rsp_valid2, rsp_err2, mem_req_valid2, mem_req_write2, busy2;
    logic [63:0] rsp_rdata2, mem_req_addr2, mem_req_wdata2;
    logic [7:0]  mem_req_wstrb2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ysyx_22050133_lsu dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready), .mem_req_write(mem_req_write),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
        .mem_req_wstrb(mem_req_wstrb), .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_rdata(mem_rsp_rdata), .mem_rsp_err(mem_rsp_err), .busy(busy)
    );

    ysyx_22050133_lsu #(.SPLIT_MISALIGNED(0)) dut_nosplit (
        .clk(clk), .rst(rst),
        .req_valid(req_valid2), .req_ready(req_ready2), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2),
        .rsp_rdata(rsp_rdata2), .rsp_err(rsp_err2), .mem_req_valid(mem_req_valid2),
        .mem_req_ready(1'b1), .mem_req_write(mem_req_write2),
        .mem_req_addr(mem_req_addr2), .mem_req_wdata(mem_req_wdata2),
        .mem_req_wstrb(mem_req_wstrb2), .mem_rsp_valid(1'b0),
        .mem_rsp_rdata(64'd0), .mem_rsp_err(1'b0), .busy(busy2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    // Presents one request for a single cycle; returns on the negedge after acceptance.
    task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                         input logic [63:0] a, input logic [63:0] d);
        chk("req_ready_idle", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
        req_addr = a; req_wdata = d;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Zero-wait beat: checks the offered beat, accepts it, answers next cycle.
    task automatic beat(input string tag, input logic [63:0] ea, input logic ew,
                        input logic [7:0] es, input logic [63:0] ed,
                        input logic [63:0] rd, input logic er);
        chk({tag, "_valid"}, {63'd0, mem_req_valid}, 64'd1);
        chk({tag, "_addr"},  mem_req_addr, ea);
        chk({tag, "_write"}, {63'd0, mem_req_write}, {63'd0, ew});
        chk({tag, "_strb"},  {56'd0, mem_req_wstrb}, {56'd0, es});
        chk({tag, "_wdata"}, mem_req_wdata, ed);
        chk({tag, "_no_rsp"}, {63'd0, rsp_valid}, 64'd0);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        chk({tag, "_dropped"}, {63'd0, mem_req_valid}, 64'd0);
        mem_rsp_valid = 1'b1; mem_rsp_rdata = rd; mem_rsp_err = er;
        @(negedge clk);
        mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0;
    endtask

    task automatic resp(input string tag, input logic [63:0] erd, input logic eerr);
        chk({tag, "_rsp_valid"}, {63'd0, rsp_valid}, 64'd1);
        chk({tag, "_rsp_rdata"}, rsp_rdata, erd);
        chk({tag, "_rsp_err"},   {63'd0, rsp_err}, {63'd0, eerr});
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, "_rsp_done"}, {63'd0, rsp_valid}, 64'd0);
    endtask

    initial begin
        // Reset state
        @(negedge clk); @(negedge clk);
        chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_mem_req_valid", {63'd0, mem_req_valid}, 64'd0);
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_req_ready", {63'd0, req_ready}, 64'd1);

        // Aligned doubleword load
        issue(1'b0, 2'd3, 1'b0, 64'h8000_0008, 64'd0);
        chk("ld_busy", {63'd0, busy}, 64'd1);
        beat("ld", 64'h8000_0008, 1'b0, 8'h00, 64'd0, 64'h1122_3344_5566_7788, 1'b0);
        resp("ld", 64'h1122_3344_5566_7788, 1'b0);

        // Signed and unsigned byte loads from lane 5
        issue(1'b0, 2'd0, 1'b0, 64'h8000_0005, 64'd0);
        beat("lb", 64'h8000_0000, 1'b0, 8'h00, 64'd0, 64'h0000_8000_0000_0000, 1'b0);
        resp("lb", 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
        issue(1'b0, 2'd0, 1'b1, 64'h8000_0005, 64'd0);
        beat("lbu", 64'h8000_0000, 1'b0, 8'h00, 64'd0, 64'h0000_8000_0000_0000, 1'b0);
        resp("lbu", 64'h0000_0000_0000_0080, 1'b0);

        // Split word store
        issue(1'b1, 2'd2, 1'b0, 64'h8000_0006, 64'h0000_0000_AABB_CCDD);
        beat("sw_b0", 64'h8000_0000, 1'b1, 8'hC0, 64'hCCDD_0000_0000_0000, 64'd0, 1'b0);
        beat("sw_b1", 64'h8000_0008, 1'b1, 8'h03, 64'h0000_0000_0000_AABB, 64'd0, 1'b0);
        resp("sw", 64'd0, 1'b0);

        // Split signed word load combining both beats
        issue(1'b0, 2'd2, 1'b0, 64'h8000_000E, 64'd0);
        beat("lw_b0", 64'h8000_0008, 1'b0, 8'h00, 64'd0, 64'h1234_5678_9ABC_DEF0, 1'b0);
        beat("lw_b1", 64'h8000_0010, 1'b0, 8'h00, 64'd0, 64'h0000_0000_0000_CAFE, 1'b0);
        resp("lw", 64'hFFFF_FFFF_CAFE_1234, 1'b0);

        // Crossing store on the no-split build: error, no bus traffic
        chk("ns_req_ready", {63'd0, req_ready2}, 64'd1);
        req_valid2 = 1'b1; req_write = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 64'h8000_0006; req_wdata = 64'h0000_0000_AABB_CCDD;
        @(negedge clk);
        req_valid2 = 1'b0;
        chk("ns_mem_req_valid", {63'd0, mem_req_valid2}, 64'd0);
        chk("ns_rsp_valid", {63'd0, rsp_valid2}, 64'd1);
        chk("ns_rsp_err", {63'd0, rsp_err2}, 64'd1);
        chk("ns_busy", {63'd0, busy2}, 64'd1);
        chk("ns_rsp_rdata", rsp_rdata2, 64'd0);
        chk("ns_main_idle", {63'd0, busy}, 64'd0);
        rsp_ready2 = 1'b1;
        @(negedge clk);
        rsp_ready2 = 1'b0;
        chk("ns_rsp_done", {63'd0, rsp_valid2}, 64'd0);
        chk("ns_req_ready_back", {63'd0, req_ready2}, 64'd1);

        // Memory error propagates to rsp_err
        issue(1'b0, 2'd1, 1'b0, 64'h8000_0002, 64'd0);
        beat("lh_err", 64'h8000_0000, 1'b0, 8'h00, 64'd0, 64'h0000_0000_ABCD_0000, 1'b1);
        resp("lh_err", 64'hFFFF_FFFF_FFFF_ABCD, 1'b1);

        // Back-pressure on both handshakes
        issue(1'b0, 2'd3, 1'b0, 64'h8000_0010, 64'd0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_mem_req_valid", {63'd0, mem_req_valid}, 64'd1);
            chk("bp_mem_req_addr", mem_req_addr, 64'h8000_0010);
            chk("bp_req_ready", {63'd0, req_ready}, 64'd0);
            chk("bp_busy", {63'd0, busy}, 64'd1);
            @(negedge clk);
        end
        beat("bp", 64'h8000_0010, 1'b0, 8'h00, 64'd0, 64'hA5A5_5A5A_0102_0304, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("bp_rsp_valid", {63'd0, rsp_valid}, 64'd1);
            chk("bp_rsp_rdata", rsp_rdata, 64'hA5A5_5A5A_0102_0304);
            chk("bp_rsp_req_ready", {63'd0, req_ready}, 64'd0);
            chk("bp_rsp_busy", {63'd0, busy}, 64'd1);
            @(negedge clk);
        end
        resp("bp", 64'hA5A5_5A5A_0102_0304, 1'b0);

        // Reset while waiting on the second beat of a split doubleword store
        issue(1'b1, 2'd3, 1'b0, 64'h8000_0004, 64'h0102_0304_0506_0708);
        beat("sd_b0", 64'h8000_0000, 1'b1, 8'hF0, 64'h0506_0708_0000_0000, 64'd0, 1'b0);
        chk("sd_b1_addr", mem_req_addr, 64'h8000_0008);
        chk("sd_b1_strb", {56'd0, mem_req_wstrb}, 64'h0F);
        chk("sd_b1_wdata", mem_req_wdata, 64'h0000_0000_0102_0304);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        chk("sd_wait1_busy", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        #1;
        chk("arst_mem_req_valid", {63'd0, mem_req_valid}, 64'd0);
        chk("arst_mem_req_addr", mem_req_addr, 64'd0);
        chk("arst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_req_ready", {63'd0, req_ready}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 64'hDEAD_BEEF_DEAD_BEEF; mem_rsp_err = 1'b1;
        @(negedge clk);
        mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0;
        chk("stale_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("stale_busy", {63'd0, busy}, 64'd0);
        issue(1'b0, 2'd3, 1'b0, 64'h8000_0020, 64'd0);
        beat("ld2", 64'h8000_0020, 1'b0, 8'h00, 64'd0, 64'h0F0E_0D0C_0B0A_0908, 1'b0);
        resp("ld2", 64'h0F0E_0D0C_0B0A_0908, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
